// File: rtl/mag_peak_detector.sv
// mag_peak_detector
//   Per-frame statistics over a squared-magnitude sample stream. For each
//   frame (terminated by in_last) it reports:
//     - the peak sample and the index of its first occurrence;
//     - how many cells were at or above the threshold captured on the
//       frame's first beat;
//     - the frame length (saturating) and whether the frame overflowed
//       2^IDX_W cells.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high. The producer holds its payload stable while valid is
//   high and ready is low. valid never depends on ready.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     input sample handshake
//   in_data, in_last      unsigned sample, last cell of frame
//   threshold             detection threshold, sampled on first beat
//   out_valid/out_ready   frame result handshake
//   out_peak, out_index   peak sample and its cell index
//   out_count             cells with sample >= captured threshold
//   out_len, out_overflow frame length (saturating), overflow flag
//   dbg_state             current FSM state (0=FIRST, 1=ACCUM, 2=HOLD)
module mag_peak_detector #(
  parameter int DATA_W = 30,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DATA_W-1:0] threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_peak,
  output logic [IDX_W-1:0]  out_index,
  output logic [IDX_W:0]    out_count,
  output logic [IDX_W:0]    out_len,
  output logic              out_overflow,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // 2^IDX_W: saturation point of the cell and hit counters.
  localparam logic [IDX_W:0] FULL    = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] ONE     = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   peak_q, peak_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      ctr_q, ctr_d;
  logic [IDX_W:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]   thr_q, thr_d;
  logic                ovf_q, ovf_d;
  logic                beat;
  logic                at_full;

  assign in_ready  = (state_q != S_HOLD) && !rst;
  assign out_valid = (state_q == S_HOLD);
  assign dbg_state = state_q;
  assign beat      = in_valid && in_ready;
  assign at_full   = (ctr_q == FULL);

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    idx_d   = idx_q;
    ctr_d   = ctr_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_FIRST: begin
        if (beat) begin
          peak_d  = in_data;
          idx_d   = '0;
          ctr_d   = ONE;
          thr_d   = threshold;
          cnt_d   = (in_data >= threshold) ? ONE : '0;
          ovf_d   = 1'b0;
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          // Strict compare: ties keep the earlier index. A peak found past
          // the index range is pinned to the last representable index.
          if (in_data > peak_q) begin
            peak_d = in_data;
            idx_d  = at_full ? LAST_IDX : ctr_q[IDX_W-1:0];
          end
          if ((in_data >= thr_q) && (cnt_q != FULL)) begin
            cnt_d = cnt_q + ONE;
          end
          if (at_full) begin
            ovf_d = 1'b1;
          end else begin
            ctr_d = ctr_q + ONE;
          end
          if (in_last) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_FIRST;
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FIRST;
      peak_q  <= '0;
      idx_q   <= '0;
      ctr_q   <= '0;
      cnt_q   <= '0;
      thr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      idx_q   <= idx_d;
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers load with the post-beat values on the in_last beat and
  // otherwise keep the previous frame's result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_peak     <= '0;
      out_index    <= '0;
      out_count    <= '0;
      out_len      <= '0;
      out_overflow <= 1'b0;
    end else if (beat && in_last) begin
      out_peak     <= peak_d;
      out_index    <= idx_d;
      out_count    <= cnt_d;
      out_len      <= ctr_d;
      out_overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mag_peak_detector.sv
module tb_mag_peak_detector;

  localparam int DW   = 30;
  localparam int IW   = 4;
  localparam int MAXC = 1 << IW;
  localparam int RW   = DW + IW + 2 * (IW + 1) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [DW-1:0] threshold;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_peak;
  logic [IW-1:0] out_index;
  logic [IW:0]   out_count;
  logic [IW:0]   out_len;
  logic          out_overflow;
  logic [1:0]    dbg_state;

  mag_peak_detector #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_peak(out_peak), .out_index(out_index), .out_count(out_count),
    .out_len(out_len), .out_overflow(out_overflow), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] frame_q[$];
  logic [RW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Frame result from plain rules: first-occurrence maximum, count of
  // samples >= thr, all clipped to what the result fields can represent.
  task automatic model_push(input logic [DW-1:0] thr);
    int n;
    int pi;
    int hits;
    int idx;
    logic [DW-1:0] pk;
    n = frame_q.size();
    pi = -1;
    hits = 0;
    pk = '0;
    for (int i = 0; i < n; i++) begin
      if (pi < 0 || frame_q[i] > pk) begin
        pk = frame_q[i];
        pi = i;
      end
      if (frame_q[i] >= thr) hits++;
    end
    idx = (pi > MAXC - 1) ? MAXC - 1 : pi;
    exp_q.push_back({pk, IW'(idx), (IW+1)'((hits > MAXC) ? MAXC : hits),
                     (IW+1)'((n > MAXC) ? MAXC : n), (n > MAXC)});
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame(input logic [DW-1:0] thr, input logic [DW-1:0] thr_late,
                            input bit gaps, input bit no_last);
    int i;
    int guard;
    bit rdy;
    i = 0;
    guard = 0;
    while (i < frame_q.size()) begin
      @(negedge clk);
      threshold = (i == 0) ? thr : thr_late;
      in_data   = frame_q[i];
      in_last   = !no_last && (i == frame_q.size() - 1);
      in_valid  = !(gaps && $urandom_range(0, 3) == 0);
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) i++;
      guard++;
      if (guard > 2000) begin
        n_checks++;
        n_err++;
        $display("FAIL send_timeout: accepted %0d beats, required %0d", i, frame_q.size());
        break;
      end
    end
  endtask

  // Picks up one result, optionally holding out_ready low for 'hold' cycles.
  task automatic collect(input string name, input int hold);
    logic [RW-1:0] e;
    logic [DW-1:0] ep;
    logic [IW-1:0] ei;
    logic [IW:0]   ec;
    logic [IW:0]   el;
    logic          eo;
    int waited;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = (hold == 0);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: out_valid=%b one cycle after last beat, required 1", name, out_valid);
    end
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_scoreboard: no expected result queued, required one", name);
      return;
    end
    e = exp_q.pop_front();
    {ep, ei, ec, el, eo} = e;
    n_checks++;
    if (out_peak !== ep) begin
      n_err++; $display("FAIL %s_peak: got %0d, required %0d", name, out_peak, ep);
    end
    n_checks++;
    if (out_index !== ei) begin
      n_err++; $display("FAIL %s_index: got %0d, required %0d", name, out_index, ei);
    end
    n_checks++;
    if (out_count !== ec) begin
      n_err++; $display("FAIL %s_count: got %0d, required %0d", name, out_count, ec);
    end
    n_checks++;
    if (out_len !== el) begin
      n_err++; $display("FAIL %s_len: got %0d, required %0d", name, out_len, el);
    end
    n_checks++;
    if (out_overflow !== eo) begin
      n_err++; $display("FAIL %s_overflow: got %b, required %b", name, out_overflow, eo);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL %s_hold_ready: in_ready=%b while holding, required 0", name, in_ready);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_peak, out_index, out_count, out_len, out_overflow} !== e) begin
        n_err++;
        $display("FAIL %s_stable: cycle %0d valid=%b ready=%b result=%h, required valid=1 ready=0 result=%h",
                 name, k, out_valid, in_ready,
                 {out_peak, out_index, out_count, out_len, out_overflow}, e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b after handshake, required 0 and 1",
               name, out_valid, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    threshold = '0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    n_checks++;
    if ({out_peak, out_index, out_count, out_len, out_overflow} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h, required 0",
                        {out_peak, out_index, out_count, out_len, out_overflow});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    frame_q = '{30'd5, 30'd9, 30'd3, 30'd9, 30'd1};
    model_push(30'd4);
    send_frame(30'd4, 30'd4, 1'b0, 1'b0);
    collect("basic", 0);
  endtask

  task automatic test_single_max();
    frame_q = '{30'h3FFFFFFF};
    model_push(30'h3FFFFFFF);
    send_frame(30'h3FFFFFFF, 30'h3FFFFFFF, 1'b0, 1'b0);
    collect("single_max", 0);
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_err++; $display("FAIL single_max_state: state=%0d, required 0 (FIRST)", dbg_state);
    end
  endtask

  task automatic test_backpressure();
    frame_q = '{30'd12, 30'd40, 30'd7};
    model_push(30'd10);
    send_frame(30'd10, 30'd10, 1'b0, 1'b0);
    collect("backpressure", 10);
  endtask

  task automatic test_overflow();
    frame_q = {};
    for (int i = 0; i < 18; i++) frame_q.push_back((i == 17) ? 30'd100 : 30'd10);
    model_push(30'd50);
    send_frame(30'd50, 30'd50, 1'b0, 1'b0);
    collect("overflow", 0);
  endtask

  task automatic test_thr_change();
    frame_q = '{30'd6, 30'd7, 30'd8};
    model_push(30'd4);
    send_frame(30'd4, 30'd100, 1'b0, 1'b0);
    collect("thr_midframe", 0);
    frame_q = '{30'd6};
    model_push(30'd100);
    send_frame(30'd100, 30'd100, 1'b0, 1'b0);
    collect("thr_next", 0);
  endtask

  task automatic test_reset_midframe();
    frame_q = '{30'd50, 30'd60, 30'd70};
    send_frame(30'd0, 30'd0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_peak !== '0) begin
      n_err++; $display("FAIL midreset: in_ready=%b out_valid=%b out_peak=%0d, required 0 0 0",
                        in_ready, out_valid, out_peak);
    end
    @(negedge clk);
    rst = 1'b0;
    frame_q = '{30'd2, 30'd1};
    model_push(30'd0);
    send_frame(30'd0, 30'd0, 1'b0, 1'b0);
    collect("after_reset", 0);
  endtask

  task automatic test_random();
    logic [DW-1:0] thr;
    logic [DW-1:0] thr_late;
    int len;
    for (int f = 0; f < 30; f++) begin
      frame_q = {};
      len = $urandom_range(1, 22);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) frame_q.push_back(DW'($urandom));
        else frame_q.push_back(DW'($urandom_range(0, 15)));
      end
      case ($urandom_range(0, 3))
        0: thr = '0;
        1: thr = {DW{1'b1}};
        default: thr = DW'($urandom_range(0, 16));
      endcase
      thr_late = DW'($urandom);
      if (f % 5 == 0) frame_q[0] = {DW{1'b1}};
      model_push(thr);
      send_frame(thr, thr_late, 1'b1, 1'b0);
      collect("random", $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      frame_q = {};
      for (int i = 0; i <= f; i++) frame_q.push_back(DW'($urandom_range(0, 9)));
      model_push(30'd5);
      send_frame(30'd5, 30'd5, 1'b0, 1'b0);
      collect("back_to_back", 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_max();
    test_backpressure();
    test_overflow();
    test_thr_change();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mag_peak_detector.md
Name: mag_peak_detector

Overview:
- Consumes the registered 30-bit squared-magnitude stream from the mod-squared stage, one range cell per accepted beat, framed by in_last.
- Per frame, reports:
  - peak power and its cell index;
  - number of cells at or above a configurable threshold;
  - frame length and overflow status.
- Sits directly downstream of the mod-squared unit, ahead of the detection/report logic.
- Valid/ready on both sides; a held result backpressures the input.

Parameters:
- DATA_W, 30: width of power samples and threshold.
- IDX_W, 10: width of cell index; max supported frame length is 2^IDX_W cells.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  squared-magnitude sample, unsigned.
- in_last  in  1  final cell of current frame.
- threshold  in  DATA_W  detection threshold, unsigned; captured on the first beat of each frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts result.
- out_peak  out  DATA_W  maximum sample in frame.
- out_index  out  IDX_W  cell index of out_peak (0 = first cell).
- out_count  out  IDX_W+1  number of cells with sample >= captured threshold.
- out_len  out  IDX_W+1  number of cells in frame, saturating.
- out_overflow  out  1  frame exceeded 2^IDX_W cells.

Behaviour:
- Reset (async, any time, including mid-frame or while holding a result):
  - state=FIRST; in_ready=0 during rst, 1 on the first cycle after release.
  - out_valid=0; out_peak, out_index, out_count, out_len=0; out_overflow=0.
  - All internal accumulators cleared; any partial frame discarded.
- Beat = in_valid && in_ready at a rising edge.
- States:
  - FIRST (awaiting first cell of a frame):
    - in_ready=1.
    - On a beat: cur_peak=in_data, cur_idx=0, cell_ctr=1, thr_q=threshold, cnt=(in_data>=threshold), ovf=0.
    - If in_last: go to HOLD (single-cell frame). Else: go to ACCUM.
  - ACCUM:
    - in_ready=1.
    - On a beat:
      - If in_data > cur_peak (strict), update cur_peak=in_data and cur_idx=cell_ctr[IDX_W-1:0]. Ties keep the earlier index.
      - cnt += (in_data >= thr_q).
      - cell_ctr += 1.
    - Saturation:
      - cell_ctr saturates at 2^IDX_W.
      - A beat arriving when cell_ctr == 2^IDX_W sets ovf=1.
      - Cells beyond 2^IDX_W still take part in the peak and count comparisons.
      - out_index for a post-overflow peak is 2^IDX_W-1.
      - cnt saturates at 2^IDX_W.
    - Beat with in_last: go to HOLD.
  - HOLD:
    - in_ready=0; out_valid=1.
    - Outputs come from registers loaded on the last beat and are stable while out_valid && !out_ready.
    - On out_valid && out_ready: out_valid=0, go to FIRST.
    - No input accepted in the same cycle as the result handshake; the next frame's first beat is accepted at the earliest one cycle after.
- Latency: out_valid rises on the clock edge that accepts the in_last beat (visible in the following cycle). Minimum frame-to-frame spacing is 1 idle input cycle.
- Output registers hold their last values after the handshake until overwritten by the next frame; only out_valid qualifies them.
- in_valid low mid-frame: state and accumulators hold, no timeout.
- threshold changes mid-frame have no effect until the next frame's first beat.
- All compares are unsigned, full DATA_W width. Threshold 0: every cell counts. Threshold all-ones: only all-ones samples count.

Test Plan:
- Frame {5,9,3,9,1}, threshold=4, out_ready=1 → out_valid 1 cycle after last beat; peak=9, index=1, count=3, len=5, overflow=0.
- Single-cell frame in_data=0x3FFFFFFF with in_last, threshold=0x3FFFFFFF → peak=0x3FFFFFFF, index=0, count=1, len=1, then returns to FIRST.
- Backpressure: out_ready=0 for 10 cycles after a frame → in_ready=0 and outputs stable throughout; in_ready=1 one cycle after the out_ready handshake.
- IDX_W=4, 18-cell frame with peak 100 at cell 17 (others 10), threshold=50 → overflow=1, len=16, index=15, count=1, peak=100.
- Threshold changed from 4 to 100 mid-frame of {6,7,8} → count=3 (captured 4); next frame {6} sees count=0.
- rst pulsed mid-frame after 3 cells, then frame {2,1} → peak=2, index=0, len=2; no contamination from the aborted frame.
